// File: rtl/vga3_pkg.sv
// Shared defaults, fetch FSM encoding and counter-width helpers for the VGA3 video path.
package vga3_pkg;

    localparam int AWIDTH_DEF = 18;
    localparam int DWIDTH_DEF = 8;
    localparam int HBYTES_DEF = 480;
    localparam int VLINES_DEF = 480;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LINE = 2'd1,
        FETCH     = 2'd2
    } fetch_state_t;

    // A counter for n values never needs fewer than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BYTE_CNT_W = cnt_w(HBYTES_DEF);
    localparam int LINE_CNT_W = cnt_w(VLINES_DEF);

endpackage

// File: rtl/vram_rdpipe.sv
// SRAM read-return pipeline: RDLAT-deep valid shift register, data captured at the tap.
module vram_rdpipe #(
    parameter int DWIDTH = 8,
    parameter int RDLAT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              squash,
    input  logic              rd_en,
    input  logic [DWIDTH-1:0] mem_data,
    output logic [DWIDTH-1:0] data,
    output logic              valid
);

    logic [RDLAT-1:0] vld_p0;

    always_ff @(posedge clk) begin
        if (!rst_n || squash) begin
            vld_p0 <= '0;
            valid  <= 1'b0;
        end else begin
            vld_p0[0] <= rd_en;
            for (int i = 1; i < RDLAT; i++) begin
                vld_p0[i] <= vld_p0[i-1];
            end
            valid <= vld_p0[RDLAT-1];
        end
    end

    // mem_data is valid exactly when the tap valid is set; hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '0;
        end else if (vld_p0[RDLAT-1] && !squash) begin
            data <= mem_data;
        end
    end

endmodule

// File: rtl/vram_fetch.sv
// Frame-memory line fetcher feeding the 3-to-4 decompressor FIFO.
// Optional VRAM_FETCH_DOUBLESCAN_EN: every source line is fetched twice.
module vram_fetch
    import vga3_pkg::*;
#(
    parameter int AWIDTH   = AWIDTH_DEF,
    parameter int DWIDTH   = DWIDTH_DEF,
    parameter int HBYTES   = HBYTES_DEF,
    parameter int VLINES   = VLINES_DEF,
    parameter int BASEADDR = 0,
    parameter int RDLAT    = 2
) (
    input  logic              PixelClk,
    input  logic              ResetN,
    input  logic              FrameStart,
    input  logic              LineStart,
    input  logic              FifoFull,
    output logic [AWIDTH-1:0] MemAddr,
    output logic              MemRdEn,
    input  logic [DWIDTH-1:0] MemData,
    output logic [DWIDTH-1:0] ByteOut,
    output logic              ByteValid,
    output logic              FrameDone,
    output logic              Overrun
);

    localparam int BW = cnt_w(HBYTES);
    localparam int LW = cnt_w(VLINES);
    localparam logic [AWIDTH-1:0] BASE      = AWIDTH'(BASEADDR);
    localparam logic [BW-1:0]     BYTE_LAST = BW'(HBYTES - 1);
    localparam logic [LW-1:0]     LINE_LAST = LW'(VLINES - 1);
`ifdef VRAM_FETCH_DOUBLESCAN_EN
    localparam logic [AWIDTH-1:0] REWIND    = AWIDTH'(HBYTES - 1);
`endif

    fetch_state_t      state, state_nxt;
    logic [AWIDTH-1:0] addr, addr_nxt;
    logic [BW-1:0]     byte_cnt, byte_nxt;
    logic [LW-1:0]     line_cnt, line_nxt;
    logic              overrun_nxt;
    logic              squash;

    always_ff @(posedge PixelClk) begin
        if (!ResetN) begin
            state    <= IDLE;
            addr     <= BASE;
            byte_cnt <= '0;
            line_cnt <= '0;
            Overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr     <= addr_nxt;
            byte_cnt <= byte_nxt;
            line_cnt <= line_nxt;
            Overrun  <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr;
        byte_nxt    = byte_cnt;
        line_nxt    = line_cnt;
        overrun_nxt = Overrun;
        MemRdEn     = 1'b0;
        FrameDone   = 1'b0;
        squash      = 1'b0;
        // FrameStart overrides everything, including a coincident LineStart.
        if (FrameStart) begin
            state_nxt = WAIT_LINE;
            addr_nxt  = BASE;
            line_nxt  = '0;
            squash    = 1'b1;
        end else begin
            case (state)
                IDLE: ;
                WAIT_LINE: begin
                    if (LineStart) begin
                        byte_nxt  = '0;
                        state_nxt = FETCH;
                    end
                end
                FETCH: begin
                    if (LineStart) begin
                        overrun_nxt = 1'b1;
                    end
                    if (!FifoFull) begin
                        MemRdEn  = 1'b1;
                        addr_nxt = addr + 1'b1;
                        byte_nxt = byte_cnt + 1'b1;
                        if (byte_cnt == BYTE_LAST) begin
                            if (line_cnt == LINE_LAST) begin
                                FrameDone = 1'b1;
                                state_nxt = IDLE;
                            end else begin
                                line_nxt  = line_cnt + 1'b1;
                                state_nxt = WAIT_LINE;
                            end
`ifdef VRAM_FETCH_DOUBLESCAN_EN
                            // Even output lines are the first pass of a source line.
                            if (!line_cnt[0]) begin
                                addr_nxt = addr - REWIND;
                            end
`endif
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign MemAddr = addr;

    vram_rdpipe #(
        .DWIDTH (DWIDTH),
        .RDLAT  (RDLAT)
    ) u_rdpipe (
        .clk      (PixelClk),
        .rst_n    (ResetN),
        .squash   (squash),
        .rd_en    (MemRdEn),
        .mem_data (MemData),
        .data     (ByteOut),
        .valid    (ByteValid)
    );

endmodule

// File: tb/tb_vram_fetch.sv
// Scenario bench for vram_fetch with HBYTES=4 and an RDLAT=2 SRAM model.
module tb_vram_fetch;

    localparam int AW = 18;
    localparam int DW = 8;
    localparam int HB = 4;
    localparam int RL = 2;
`ifdef VRAM_FETCH_DOUBLESCAN_EN
    localparam int VL = 4;
    localparam bit DS = 1'b1;
`else
    localparam int VL = 2;
    localparam bit DS = 1'b0;
`endif

    logic          PixelClk = 1'b0;
    logic          ResetN = 1'b0;
    logic          FrameStart = 1'b0;
    logic          LineStart = 1'b0;
    logic          FifoFull = 1'b0;
    logic [AW-1:0] MemAddr;
    logic          MemRdEn;
    logic [DW-1:0] MemData;
    logic [DW-1:0] ByteOut;
    logic          ByteValid;
    logic          FrameDone;
    logic          Overrun;

    int checks = 0;
    int failures = 0;
    int nbytes = 0;
    int ndone = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_byte;
    logic [AW-1:0] addr_d[RL];

    vram_fetch #(
        .AWIDTH(AW), .DWIDTH(DW), .HBYTES(HB), .VLINES(VL), .BASEADDR(0), .RDLAT(RL)
    ) dut (
        .PixelClk(PixelClk), .ResetN(ResetN), .FrameStart(FrameStart), .LineStart(LineStart),
        .FifoFull(FifoFull), .MemAddr(MemAddr), .MemRdEn(MemRdEn), .MemData(MemData),
        .ByteOut(ByteOut), .ByteValid(ByteValid), .FrameDone(FrameDone), .Overrun(Overrun)
    );

    always #5 PixelClk = ~PixelClk;

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return 8'(a[7:0] * 8'd37) ^ 8'hA5;
    endfunction

    // SRAM model: data for the address presented RL cycles earlier.
    always @(posedge PixelClk) begin
        addr_d[0] <= MemAddr;
        for (int i = 1; i < RL; i++) addr_d[i] <= addr_d[i-1];
    end
    assign MemData = memf(addr_d[RL-1]);

    // Scoreboard: each issued read pushes its expected byte; each ByteValid pops one.
    always @(negedge PixelClk) begin
        if (ByteValid === 1'b1) begin
            checks++;
            nbytes++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL byte_unexpected: ByteOut=%h delivered, no byte expected", ByteOut);
            end else begin
                exp_byte = exp_q.pop_front();
                if (ByteOut !== exp_byte) begin
                    failures++;
                    $display("FAIL byte_data: ByteOut=%h expected %h", ByteOut, exp_byte);
                end
            end
        end
        if (MemRdEn === 1'b1) exp_q.push_back(memf(MemAddr));
        if (FrameDone === 1'b1) ndone++;
        if (FrameStart || !ResetN) exp_q.delete();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge PixelClk);
        #1;
    endtask

    task automatic start_frame_line();
        FrameStart = 1'b1;
        step();
        FrameStart = 1'b0;
        LineStart = 1'b1;
        step();
        LineStart = 1'b0;
    endtask

    task automatic test_reset();
        ResetN = 1'b0;
        step();
        step();
        @(negedge PixelClk);
        checks++; if (MemAddr !== '0) begin failures++; $display("FAIL reset_addr: MemAddr=%0d expected 0", MemAddr); end
        checks++; if (MemRdEn !== 1'b0) begin failures++; $display("FAIL reset_rden: MemRdEn=%b expected 0", MemRdEn); end
        checks++; if (ByteValid !== 1'b0) begin failures++; $display("FAIL reset_valid: ByteValid=%b expected 0", ByteValid); end
        checks++; if (ByteOut !== '0) begin failures++; $display("FAIL reset_byte: ByteOut=%h expected 00", ByteOut); end
        checks++; if (FrameDone !== 1'b0) begin failures++; $display("FAIL reset_done: FrameDone=%b expected 0", FrameDone); end
        checks++; if (Overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: Overrun=%b expected 0", Overrun); end
        step();
        ResetN = 1'b1;
        LineStart = 1'b1;
        step();
        LineStart = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge PixelClk);
            checks++;
            if (MemRdEn !== 1'b0) begin failures++; $display("FAIL idle_linestart: cycle %0d MemRdEn=%b expected 0", k, MemRdEn); end
            step();
        end
    endtask

    task automatic test_line_basic();
        int n0;
        n0 = nbytes;
        start_frame_line();
        for (int k = 0; k < 12; k++) begin
            @(negedge PixelClk);
            checks++;
            if (MemRdEn !== (k < 4)) begin failures++; $display("FAIL basic_rden: cycle %0d MemRdEn=%b expected %b", k, MemRdEn, (k < 4)); end
            if (k < 4) begin
                checks++;
                if (MemAddr !== AW'(k)) begin failures++; $display("FAIL basic_addr: cycle %0d MemAddr=%0d expected %0d", k, MemAddr, k); end
            end
            checks++;
            if (ByteValid !== (k >= 3 && k < 7)) begin failures++; $display("FAIL basic_valid: cycle %0d ByteValid=%b expected %b", k, ByteValid, (k >= 3 && k < 7)); end
            step();
        end
        checks++;
        if (nbytes - n0 != HB) begin failures++; $display("FAIL basic_count: %0d bytes expected %0d", nbytes - n0, HB); end
    endtask

    function automatic bit stall_rd(input int k);
        return (k >= 0 && k < 2) || (k >= 5 && k < 7);
    endfunction

    task automatic test_fifo_stall();
        int n0;
        int ea;
        n0 = nbytes;
        start_frame_line();
        for (int k = 0; k < 14; k++) begin
            FifoFull = (k >= 2 && k < 5);
            ea = (k < 2) ? k : (k < 5) ? 2 : k - 3;
            @(negedge PixelClk);
            checks++;
            if (MemRdEn !== stall_rd(k)) begin failures++; $display("FAIL stall_rden: cycle %0d MemRdEn=%b expected %b", k, MemRdEn, stall_rd(k)); end
            if (k < 7) begin
                checks++;
                if (MemAddr !== AW'(ea)) begin failures++; $display("FAIL stall_addr: cycle %0d MemAddr=%0d expected %0d", k, MemAddr, ea); end
            end
            checks++;
            if (ByteValid !== stall_rd(k - 3)) begin failures++; $display("FAIL stall_valid: cycle %0d ByteValid=%b expected %b", k, ByteValid, stall_rd(k - 3)); end
            step();
        end
        FifoFull = 1'b0;
        checks++;
        if (nbytes - n0 != HB) begin failures++; $display("FAIL stall_count: %0d bytes expected %0d", nbytes - n0, HB); end
    endtask

    task automatic test_frame();
        int n0, d0, base;
        n0 = nbytes;
        d0 = ndone;
        FrameStart = 1'b1;
        step();
        FrameStart = 1'b0;
        for (int l = 0; l < VL; l++) begin
            LineStart = 1'b1;
            step();
            LineStart = 1'b0;
            base = (DS ? l / 2 : l) * HB;
            for (int i = 0; i < HB; i++) begin
                @(negedge PixelClk);
                checks++;
                if (MemRdEn !== 1'b1 || MemAddr !== AW'(base + i)) begin
                    failures++;
                    $display("FAIL frame_addr: line %0d byte %0d MemRdEn=%b MemAddr=%0d expected 1/%0d", l, i, MemRdEn, MemAddr, base + i);
                end
                checks++;
                if (FrameDone !== (l == VL - 1 && i == HB - 1)) begin
                    failures++;
                    $display("FAIL frame_done: line %0d byte %0d FrameDone=%b expected %b", l, i, FrameDone, (l == VL - 1 && i == HB - 1));
                end
                step();
            end
        end
        LineStart = 1'b1;
        step();
        LineStart = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge PixelClk);
            checks++;
            if (MemRdEn !== 1'b0) begin failures++; $display("FAIL frame_idle: cycle %0d MemRdEn=%b expected 0", k, MemRdEn); end
            step();
        end
        checks++;
        if (ndone - d0 != 1) begin failures++; $display("FAIL frame_done_count: %0d pulses expected 1", ndone - d0); end
        checks++;
        if (nbytes - n0 != HB * VL) begin failures++; $display("FAIL frame_count: %0d bytes expected %0d", nbytes - n0, HB * VL); end
    endtask

    task automatic test_framestart_squash();
        int n0;
        n0 = nbytes;
        start_frame_line();
        for (int k = 0; k < 2; k++) begin
            @(negedge PixelClk);
            checks++;
            if (MemRdEn !== 1'b1 || MemAddr !== AW'(k)) begin failures++; $display("FAIL squash_pre: cycle %0d MemRdEn=%b MemAddr=%0d expected 1/%0d", k, MemRdEn, MemAddr, k); end
            step();
        end
        FrameStart = 1'b1;
        LineStart = 1'b1;
        step();
        FrameStart = 1'b0;
        LineStart = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge PixelClk);
            checks++;
            if (ByteValid !== 1'b0 || MemRdEn !== 1'b0 || MemAddr !== '0) begin
                failures++;
                $display("FAIL squash_quiet: cycle %0d ByteValid=%b MemRdEn=%b MemAddr=%0d expected 0/0/0", k, ByteValid, MemRdEn, MemAddr);
            end
            step();
        end
        checks++;
        if (nbytes != n0) begin failures++; $display("FAIL squash_count: %0d bytes expected 0", nbytes - n0); end
        LineStart = 1'b1;
        step();
        LineStart = 1'b0;
        for (int i = 0; i < HB; i++) begin
            @(negedge PixelClk);
            checks++;
            if (MemRdEn !== 1'b1 || MemAddr !== AW'(i)) begin failures++; $display("FAIL squash_refetch: byte %0d MemRdEn=%b MemAddr=%0d expected 1/%0d", i, MemRdEn, MemAddr, i); end
            step();
        end
        repeat (6) step();
        checks++;
        if (nbytes - n0 != HB) begin failures++; $display("FAIL squash_refetch_count: %0d bytes expected %0d", nbytes - n0, HB); end
    endtask

    task automatic test_overrun();
        start_frame_line();
        for (int k = 0; k < 6; k++) begin
            LineStart = (k == 2);
            @(negedge PixelClk);
            checks++;
            if (MemRdEn !== (k < 4)) begin failures++; $display("FAIL overrun_rden: cycle %0d MemRdEn=%b expected %b", k, MemRdEn, (k < 4)); end
            if (k < 4) begin
                checks++;
                if (MemAddr !== AW'(k)) begin failures++; $display("FAIL overrun_addr: cycle %0d MemAddr=%0d expected %0d", k, MemAddr, k); end
            end
            checks++;
            if (Overrun !== (k >= 3)) begin failures++; $display("FAIL overrun_flag: cycle %0d Overrun=%b expected %b", k, Overrun, (k >= 3)); end
            step();
        end
        LineStart = 1'b0;
        start_frame_line();
        repeat (8) step();
        @(negedge PixelClk);
        checks++;
        if (Overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky: Overrun=%b expected 1", Overrun); end
        step();
        ResetN = 1'b0;
        step();
        ResetN = 1'b1;
        @(negedge PixelClk);
        checks++;
        if (Overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear: Overrun=%b expected 0", Overrun); end
        step();
    endtask

    task automatic test_reset_midline();
        int n0;
        start_frame_line();
        repeat (2) step();
        n0 = nbytes;
        ResetN = 1'b0;
        step();
        ResetN = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge PixelClk);
            checks++;
            if (ByteValid !== 1'b0 || MemRdEn !== 1'b0 || MemAddr !== '0) begin
                failures++;
                $display("FAIL midreset_quiet: cycle %0d ByteValid=%b MemRdEn=%b MemAddr=%0d expected 0/0/0", k, ByteValid, MemRdEn, MemAddr);
            end
            step();
        end
        checks++;
        if (nbytes != n0) begin failures++; $display("FAIL midreset_count: %0d bytes expected 0", nbytes - n0); end
    endtask

    initial begin
        test_reset();
        test_line_basic();
        test_fifo_stall();
        test_frame();
        test_framestart_squash();
        test_overrun();
        test_reset_midline();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain: %0d bytes outstanding expected 0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
